// File: rtl/alu_float_pkg.sv
// Shared constants, state encoding and IEEE-754 field helpers for the float-to-integer converter.
// Macro F2I_TWOS_COMP_EN selects two's-complement results; undefined gives sign-magnitude.
package alu_float_pkg;

    localparam int FLT_MANT_W = 23;
    localparam int FLT_EXP_W  = 8;
    localparam int INT_W      = 32;

    localparam logic [FLT_EXP_W-1:0] FLT_BIAS        = 8'd127;
    localparam logic [FLT_EXP_W-1:0] F2I_SHIFT_BASE  = 8'd150;
    localparam logic [FLT_EXP_W-1:0] F2I_EXP_SAT     = 8'd158;
    localparam logic [FLT_EXP_W-1:0] FLT_EXP_SPECIAL = 8'hFF;

    localparam logic [INT_W-1:0] INT_POS_SAT = 32'h7FFF_FFFF;
`ifdef F2I_TWOS_COMP_EN
    localparam logic [INT_W-1:0] INT_NEG_SAT = 32'h8000_0000;
`else
    localparam logic [INT_W-1:0] INT_NEG_SAT = 32'hFFFF_FFFF;
`endif

    // The only negative value whose exponent reaches the saturation threshold yet still fits.
    localparam logic [INT_W-1:0] FLT_MIN_INT = 32'hCF00_0000;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } f2iState_t;

    function automatic logic fltSign(input logic [INT_W-1:0] flt);
        fltSign = flt[INT_W-1];
    endfunction

    function automatic logic [FLT_EXP_W-1:0] fltExp(input logic [INT_W-1:0] flt);
        fltExp = flt[FLT_MANT_W +: FLT_EXP_W];
    endfunction

    function automatic logic [FLT_MANT_W-1:0] fltFrac(input logic [INT_W-1:0] flt);
        fltFrac = flt[FLT_MANT_W-1:0];
    endfunction

    function automatic logic [INT_W-1:0] applySign(input logic sign, input logic [INT_W-2:0] mag);
`ifdef F2I_TWOS_COMP_EN
        applySign = sign ? (~{1'b0, mag} + 32'd1) : {1'b0, mag};
`else
        applySign = {sign, mag};
`endif
    endfunction

    function automatic logic [INT_W-1:0] satValue(input logic sign);
        satValue = sign ? INT_NEG_SAT : INT_POS_SAT;
    endfunction

endpackage

// File: rtl/f2i_classify.sv
// Combinational decode of a single-precision operand: special cases, shift direction and count.
// Honours F2I_TWOS_COMP_EN for the exact -2^31 case and the sign convention of special results.
module f2i_classify
    import alu_float_pkg::*;
(
    input  logic [31:0] i_flt,
    output logic        o_sign,
    output logic        o_special,
    output logic [31:0] o_specValue,
    output logic        o_specOvf,
    output logic        o_specInv,
    output logic        o_specInexact,
    output logic [30:0] o_mag,
    output logic [4:0]  o_cnt,
    output logic        o_dirLeft
);

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_frac;

    assign w_sign = fltSign(i_flt);
    assign w_exp  = fltExp(i_flt);
    assign w_frac = fltFrac(i_flt);
    assign o_sign = w_sign;

    // Operands in 127..157 always fit in 31 bits and go to the shifter; everything else resolves here.
    always_comb begin
        o_special     = 1'b0;
        o_specValue   = 32'd0;
        o_specOvf     = 1'b0;
        o_specInv     = 1'b0;
        o_specInexact = 1'b0;
        o_mag         = 31'd0;
        o_cnt         = 5'd0;
        o_dirLeft     = 1'b0;

        if (w_exp == FLT_EXP_SPECIAL) begin
            o_special = 1'b1;
            if (w_frac != 23'd0) begin
                o_specInv = 1'b1;
            end else begin
                o_specOvf   = 1'b1;
                o_specValue = satValue(w_sign);
            end
        end else if (w_exp < FLT_BIAS) begin
            o_special     = 1'b1;
            o_specValue   = applySign(w_sign, 31'd0);
            o_specInexact = (w_exp != 8'd0) || (w_frac != 23'd0);
        end else if (w_exp >= F2I_EXP_SAT) begin
            o_special   = 1'b1;
            o_specOvf   = 1'b1;
            o_specValue = satValue(w_sign);
`ifdef F2I_TWOS_COMP_EN
            if (i_flt == FLT_MIN_INT) begin
                o_specOvf   = 1'b0;
                o_specValue = 32'h8000_0000;
            end
`endif
        end else begin
            o_mag = {7'd0, 1'b1, w_frac};
            if (w_exp < F2I_SHIFT_BASE) begin
                o_cnt     = 5'(F2I_SHIFT_BASE - w_exp);
                o_dirLeft = 1'b0;
            end else begin
                o_cnt     = 5'(w_exp - F2I_SHIFT_BASE);
                o_dirLeft = 1'b1;
            end
        end
    end

endmodule

// File: rtl/float_to_int.sv
// Iterative IEEE-754 single to 32-bit integer converter; truncates toward zero, saturates on overflow.
// Define F2I_TWOS_COMP_EN for two's-complement results; default output is sign-magnitude.
module float_to_int
    import alu_float_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] flt_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] int_value,
    output logic        ovf,
    output logic        inv,
    output logic        inexact
);

    localparam logic [4:0] STEP_AMT = 5'(STEP);

    f2iState_t   r_state;
    f2iState_t   w_nextState;

    logic [30:0] r_mag;
    logic [4:0]  r_cnt;
    logic        r_dirLeft;
    logic        r_sign;
    logic [31:0] r_intValue;
    logic        r_ovf;
    logic        r_inv;
    logic        r_inexact;

    logic        w_sign;
    logic        w_special;
    logic [31:0] w_specValue;
    logic        w_specOvf;
    logic        w_specInv;
    logic        w_specInexact;
    logic [30:0] w_mag;
    logic [4:0]  w_cnt;
    logic        w_dirLeft;

    logic [4:0]  w_amt;
    logic [4:0]  w_cntNext;
    logic [30:0] w_lostMask;
    logic        w_lost;
    logic [30:0] w_shiftedMag;

    f2i_classify uClassify (
        .i_flt         (flt_value),
        .o_sign        (w_sign),
        .o_special     (w_special),
        .o_specValue   (w_specValue),
        .o_specOvf     (w_specOvf),
        .o_specInv     (w_specInv),
        .o_specInexact (w_specInexact),
        .o_mag         (w_mag),
        .o_cnt         (w_cnt),
        .o_dirLeft     (w_dirLeft)
    );

    // Final partial step shifts only what is left so the count lands exactly on zero.
    assign w_amt        = (r_cnt < STEP_AMT) ? r_cnt : STEP_AMT;
    assign w_cntNext    = r_cnt - w_amt;
    assign w_lostMask   = (31'd1 << w_amt) - 31'd1;
    assign w_lost       = |(r_mag & w_lostMask);
    assign w_shiftedMag = r_dirLeft ? (r_mag << w_amt) : (r_mag >> w_amt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_nextState = (w_special || (w_cnt == 5'd0)) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (w_cntNext == 5'd0) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // Result and flags are written at accept (specials, zero-shift) or on the last shift cycle, then held through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mag      <= 31'd0;
            r_cnt      <= 5'd0;
            r_dirLeft  <= 1'b0;
            r_sign     <= 1'b0;
            r_intValue <= 32'd0;
            r_ovf      <= 1'b0;
            r_inv      <= 1'b0;
            r_inexact  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mag     <= w_mag;
                        r_cnt     <= w_cnt;
                        r_dirLeft <= w_dirLeft;
                        r_sign    <= w_sign;
                        if (w_special) begin
                            r_intValue <= w_specValue;
                            r_ovf      <= w_specOvf;
                            r_inv      <= w_specInv;
                            r_inexact  <= w_specInexact;
                        end else begin
                            r_intValue <= (w_cnt == 5'd0) ? applySign(w_sign, w_mag) : 32'd0;
                            r_ovf      <= 1'b0;
                            r_inv      <= 1'b0;
                            r_inexact  <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    r_mag <= w_shiftedMag;
                    r_cnt <= w_cntNext;
                    if (!r_dirLeft) begin
                        r_inexact <= r_inexact | w_lost;
                    end
                    if (w_cntNext == 5'd0) begin
                        r_intValue <= applySign(r_sign, w_shiftedMag);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign int_value = r_intValue;
    assign ovf       = r_ovf;
    assign inv       = r_inv;
    assign inexact   = r_inexact;

endmodule

// File: tb/tb_float_to_int.sv
// Randomized bench for float_to_int: two instances (STEP=1 and STEP=4) against an arithmetic reference model.
// Follows F2I_TWOS_COMP_EN so the expected sign convention matches the build.
module tb_float_to_int;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst[2];
    logic        inValid[2];
    logic        inReady[2];
    logic [31:0] fltValue[2];
    logic        outValid[2];
    logic        outReady[2];
    logic [31:0] intValue[2];
    logic        ovf[2];
    logic        inv[2];
    logic        inexact[2];

    int compareCount = 0;
    int failCount    = 0;

`ifdef F2I_TWOS_COMP_EN
    localparam logic [31:0] NEG_SAT  = 32'h8000_0000;
    localparam logic [31:0] NEG_ZERO = 32'h0000_0000;
`else
    localparam logic [31:0] NEG_SAT  = 32'hFFFF_FFFF;
    localparam logic [31:0] NEG_ZERO = 32'h8000_0000;
`endif

    for (genvar g = 0; g < 2; g++) begin : gDut
        float_to_int #(.STEP(g == 0 ? 1 : 4)) uDut (
            .clk       (clk),
            .rst       (rst[g]),
            .in_valid  (inValid[g]),
            .in_ready  (inReady[g]),
            .flt_value (fltValue[g]),
            .out_valid (outValid[g]),
            .out_ready (outReady[g]),
            .int_value (intValue[g]),
            .ovf       (ovf[g]),
            .inv       (inv[g]),
            .inexact   (inexact[g])
        );
    end

    typedef struct {
        logic [31:0] value;
        logic        ovf;
        logic        inv;
        logic        inexact;
        int          latency;
    } refResult_t;

    logic [31:0] directed[$] = '{
        32'h3F80_0000, 32'hC2F6_0000, 32'h3FC0_0000, 32'h3F00_0000, 32'h0000_0000,
        32'h4F00_0000, 32'h4EFF_FFFF, 32'h7FC0_0000, 32'hFF80_0000, 32'h4B00_0001,
        32'h8000_0000, 32'hCF00_0000, 32'h7F80_0000, 32'h0000_0001, 32'h3F7F_FFFF,
        32'h4B7F_FFFF, 32'hCEFF_FFFF, 32'h4B80_0001, 32'hFFC0_0001, 32'hBF80_0000
    };

    function automatic int stepOf(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // Value = 1.frac * 2^(e-127); truncation via integer division, exactness via the remainder.
    function automatic refResult_t refModel(input logic [31:0] f, input int step);
        refResult_t r;
        logic   sgn;
        int     e;
        int     shifts;
        longint m;
        longint mag;
        longint divisor;
        r.value   = 32'd0;
        r.ovf     = 1'b0;
        r.inv     = 1'b0;
        r.inexact = 1'b0;
        r.latency = 1;
        sgn = f[31];
        e   = int'(f[30:23]);
        m   = longint'({1'b1, f[22:0]});
        if (e == 255) begin
            if (f[22:0] != 23'd0) begin
                r.inv = 1'b1;
            end else begin
                r.ovf   = 1'b1;
                r.value = sgn ? NEG_SAT : 32'h7FFF_FFFF;
            end
        end else if (e < 127) begin
            r.inexact = (f[30:0] != 31'd0);
            r.value   = sgn ? NEG_ZERO : 32'd0;
        end else if (e >= 158) begin
            r.ovf   = 1'b1;
            r.value = sgn ? NEG_SAT : 32'h7FFF_FFFF;
`ifdef F2I_TWOS_COMP_EN
            if (f == 32'hCF00_0000) begin
                r.ovf   = 1'b0;
                r.value = 32'h8000_0000;
            end
`endif
        end else begin
            if (e >= 150) begin
                shifts = e - 150;
                mag    = m * (longint'(1) << shifts);
            end else begin
                shifts    = 150 - e;
                divisor   = longint'(1) << shifts;
                mag       = m / divisor;
                r.inexact = (m % divisor) != 0;
            end
            r.latency = 1 + (shifts + step - 1) / step;
`ifdef F2I_TWOS_COMP_EN
            r.value = sgn ? 32'(longint'(0) - mag) : 32'(mag);
`else
            r.value = sgn ? (32'h8000_0000 | 32'(mag)) : 32'(mag);
`endif
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic resetDut(input int d);
        rst[d]      = 1'b1;
        inValid[d]  = 1'b0;
        outReady[d] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst[d] = 1'b0;
        checkOutput($sformatf("d%0d reset in_ready", d), 32'(inReady[d]), 32'd1);
        checkOutput($sformatf("d%0d reset out_valid", d), 32'(outValid[d]), 32'd0);
        checkOutput($sformatf("d%0d reset int_value", d), intValue[d], 32'd0);
        checkOutput($sformatf("d%0d reset flags", d), {29'd0, ovf[d], inv[d], inexact[d]}, 32'd0);
    endtask

    task automatic applyStimulus(input int d, input logic [31:0] f, input bit backpressure);
        refResult_t ref_r;
        int         n;
        string      tag;
        ref_r = refModel(f, stepOf(d));
        tag   = $sformatf("d%0d flt=%08h", d, f);
        n     = 0;
        while (!inReady[d] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, " in_ready"}, 32'(inReady[d]), 32'd1);
        outReady[d] = backpressure ? 1'b0 : 1'b1;
        inValid[d]  = 1'b1;
        fltValue[d] = f;
        @(posedge clk);
        #1;
        inValid[d]  = 1'b0;
        fltValue[d] = $urandom;
        n = 1;
        while (!outValid[d] && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, " out_valid"}, 32'(outValid[d]), 32'd1);
        checkOutput({tag, " latency"}, 32'(n), 32'(ref_r.latency));
        checkOutput({tag, " int_value"}, intValue[d], ref_r.value);
        checkOutput({tag, " ovf"}, 32'(ovf[d]), 32'(ref_r.ovf));
        checkOutput({tag, " inv"}, 32'(inv[d]), 32'(ref_r.inv));
        checkOutput({tag, " inexact"}, 32'(inexact[d]), 32'(ref_r.inexact));
        if (backpressure) begin
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                checkOutput({tag, " hold out_valid"}, 32'(outValid[d]), 32'd1);
                checkOutput({tag, " hold int_value"}, intValue[d], ref_r.value);
                checkOutput({tag, " hold flags"}, {29'd0, ovf[d], inv[d], inexact[d]},
                            {29'd0, ref_r.ovf, ref_r.inv, ref_r.inexact});
                checkOutput({tag, " hold in_ready"}, 32'(inReady[d]), 32'd0);
            end
            outReady[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput({tag, " post in_ready"}, 32'(inReady[d]), 32'd1);
        checkOutput({tag, " post out_valid"}, 32'(outValid[d]), 32'd0);
    endtask

    task automatic midReset(input int d);
        outReady[d] = 1'b1;
        inValid[d]  = 1'b1;
        fltValue[d] = 32'h3F80_0000;
        @(posedge clk);
        #1;
        inValid[d] = 1'b0;
        @(posedge clk);
        #1;
        checkOutput($sformatf("d%0d shift in_ready", d), 32'(inReady[d]), 32'd0);
        checkOutput($sformatf("d%0d shift out_valid", d), 32'(outValid[d]), 32'd0);
        rst[d] = 1'b1;
        @(posedge clk);
        #1;
        rst[d] = 1'b0;
        checkOutput($sformatf("d%0d abort in_ready", d), 32'(inReady[d]), 32'd1);
        checkOutput($sformatf("d%0d abort out_valid", d), 32'(outValid[d]), 32'd0);
        repeat (30) @(posedge clk);
        #1;
        checkOutput($sformatf("d%0d abort no output", d), 32'(outValid[d]), 32'd0);
        applyStimulus(d, 32'h4B00_0001, 1'b0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d]      = 1'b1;
            inValid[d]  = 1'b0;
            fltValue[d] = 32'd0;
            outReady[d] = 1'b1;
        end
        for (int d = 0; d < 2; d++) begin
            $display("[TB] running instance with STEP=%0d", stepOf(d));
            resetDut(d);
            foreach (directed[i]) begin
                applyStimulus(d, directed[i], 1'b0);
            end
            applyStimulus(d, 32'h4228_0000, 1'b1);
            applyStimulus(d, 32'hC2F6_0000, 1'b1);
            midReset(d);
            repeat (40) begin
                applyStimulus(d, {1'($urandom), 8'($urandom_range(118, 162)), 23'($urandom)}, 1'b0);
            end
            repeat (20) begin
                applyStimulus(d, $urandom, 1'b0);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/float_to_int.md
Name: float_to_int

Overview:
- Sequential IEEE-754 single-precision to 32-bit integer converter; the reverse direction of the datapath's int_to_float.
- Sits at the float-to-integer output side of the logarithmic ALU.
- Valid/ready handshake on both sides.
- Iterative shifter, one conversion in flight; truncates toward zero; saturates on overflow.

Parameters:
- STEP, 1, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  flt_value valid
- in_ready  out  1  converter can accept
- flt_value  in  32  IEEE-754 single {sign, exp[7:0], frac[22:0]}
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- int_value  out  32  converted integer
- ovf  out  1  overflow or infinity (saturated)
- inv  out  1  NaN input
- inexact  out  1  nonzero bits discarded by truncation

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, int_value=0, ovf=0, inv=0, inexact=0. Reset mid-operation aborts the conversion with no output.
- States:
  - IDLE: in_ready=1. On in_valid, latch the operand and classify (rules below).
  - SHIFT: in_ready=0. Each cycle shift by min(STEP, cnt) and decrement cnt by that amount. When cnt reaches 0, go to DONE.
  - DONE: out_valid=1, outputs stable. On out_ready, go to IDLE (in_ready=1 the following cycle). No accept while in DONE.
- Classification at accept, e = exp:
  - e=255, frac!=0 -> DONE; int_value=0, inv=1.
  - e=255, frac=0 -> DONE; saturate, ovf=1.
  - e<127 (zero, denormal, |x|<1) -> DONE; int_value=0, inexact=(exp|frac)!=0.
  - e>=158 -> DONE; saturate, ovf=1.
    - Exception under F2I_TWOS_COMP_EN only: exactly -2^31 (0xCF000000) gives 0x80000000 with ovf=0.
  - Otherwise: mag = {1, frac} zero-extended to 32 bits.
    - e<150: right shift, cnt = 150-e.
    - e>150: left shift, cnt = e-150.
    - e=150: cnt = 0, go straight to DONE.
    - Else go to SHIFT.
- Right shift: OR every bit shifted out into sticky inexact. Left shift never sets inexact.
- Latency, accept edge to out_valid: 1 + ceil(cnt/STEP) cycles; specials take 1 cycle. Maximum with STEP=1 is 24.
- Final result: sign applied per feature; magnitude is at most 31 bits in range.
- Flags are valid only with out_valid and are cleared on the next accept.

Optional Feature:
- Macro F2I_TWOS_COMP_EN.
- Defined:
  - int_value is two's complement; negative results are negated in the DONE entry cycle.
  - Saturation values are 0x7FFFFFFF and 0x80000000.
- Undefined:
  - int_value is sign-magnitude {sign, mag[30:0]}, the same sign convention as int_to_float.
  - Saturation values are 0x7FFFFFFF and 0xFFFFFFFF.
  - -0.0 gives 0x80000000.

Decomposition:
- Package alu_float_pkg:
  - FLT_BIAS=127, FLT_MANT_W=23, FLT_EXP_W=8, INT_W=32, F2I_SHIFT_BASE=150.
  - State enum typedef {IDLE, SHIFT, DONE}.
  - Field-extract functions.
- Sub-module f2i_classify: combinational special-case, cnt and direction decode. Feeds the FSM/shifter in float_to_int.

Test Plan:
- 0x3F800000 (1.0), STEP=1 -> out_valid 24 cycles after accept; int_value=0x00000001, inexact=0.
- 0xC2F60000 (-123.0) -> sign-magnitude 0x8000007B, two's complement 0xFFFFFF85. 0x3FC00000 (1.5) -> 1, inexact=1.
- 0x3F000000 (0.5) -> out_valid 1 cycle after accept; int_value=0, inexact=1. 0x00000000 -> 0, all flags 0.
- Limits and specials:
  - 0x4F000000 (2^31) -> 0x7FFFFFFF, ovf=1.
  - 0x4EFFFFFF -> 0x7FFFFF80, ovf=0.
  - 0x7FC00000 -> 0, inv=1.
  - 0xFF800000 -> negative saturation, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid, int_value and flags stable; in_ready=0 throughout. Then out_ready=1 -> in_ready=1 next cycle.
- Reset and STEP sweep:
  - Assert rst mid-SHIFT -> next cycle IDLE, out_valid=0, in_ready=1. A following 0x4B000001 converts to 0x00800001.
  - Repeat the whole plan with STEP=4 -> same values; latency matches 1 + ceil(cnt/4).
